// File: rtl/if_id_stage.sv
// IF/ID boundary: pairs 1-cycle imem read data with its PC, holds the word across decode stalls.
// Optional stall/flush performance counters are enabled with `define IF_ID_PERF_EN.
module if_id_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC_if,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall_id,
  input  logic        flush_id,
  output logic        fetch_hold,
  output logic [31:0] PC_id,
  output logic [31:0] instr_id,
  output logic        valid_id,
  output logic        misaligned_id,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
);

  logic [31:0] pc_q;
  logic        valid_q;
  logic [31:0] instr_hold;
  logic        hold_sel;

  assign imem_addr  = PC_if;
  assign fetch_hold = stall_id & ~flush_id;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
      hold_sel   <= 1'b0;
      instr_hold <= 32'h0;
    end else if (flush_id) begin
      pc_q     <= PC_if;
      valid_q  <= 1'b0;
      hold_sel <= 1'b0;
    end else if (stall_id) begin
      // The RAM moves on to the held fetch address next cycle, so latch the
      // word belonging to pc_q now; later stall cycles keep the first capture.
      if (!hold_sel) begin
        instr_hold <= imem_rdata;
        hold_sel   <= 1'b1;
      end
    end else begin
      pc_q     <= PC_if;
      valid_q  <= 1'b1;
      hold_sel <= 1'b0;
    end
  end

  always_comb begin
    instr_id = imem_rdata;
    if (!valid_q)
      instr_id = NOP_INSTR;
    else if (hold_sel)
      instr_id = instr_hold;
  end

  assign PC_id         = pc_q;
  assign valid_id      = valid_q;
  assign misaligned_id = valid_q & (pc_q[1:0] != 2'b00);

`ifdef IF_ID_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 32'h0;
      flush_cnt_q <= 32'h0;
    end else begin
      if (stall_id && !flush_id)
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush_id)
        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`else
  assign perf_stall_cnt = 32'h0;
  assign perf_flush_cnt = 32'h0;
`endif

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- IF/ID pipeline boundary of the RV32 core, directly downstream of the fetch PC register.
- Drives the synchronous instruction memory address from the fetch PC.
- Pairs the 1-cycle-latency read data with its PC and presents a valid instruction to decode.
- Handles decode stalls with a hold (skid) register, handles branch flushes, and back-pressures fetch.

Parameters:
- NOP_INSTR, 32'h00000013, instruction word presented to decode when the slot is invalid (addi x0,x0,0).
- RESET_PC, 32'h00000000, value of PC_id after reset.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- PC_if  in  32  current fetch PC from fetch stage
- imem_addr  out  32  instruction memory address; combinational copy of PC_if
- imem_rdata  in  32  instruction memory read data; valid the cycle after imem_addr
- stall_id  in  1  decode cannot accept a new instruction this cycle (hazard unit)
- flush_id  in  1  taken branch resolved; kill the instruction being captured
- fetch_hold  out  1  fetch must not advance PC this cycle
- PC_id  out  32  PC of the instruction in decode
- instr_id  out  32  instruction word to decode
- valid_id  out  1  decode slot holds a live instruction
- misaligned_id  out  1  PC_id[1:0] != 0 and valid_id
- perf_stall_cnt  out  32  stall-cycle counter (optional feature)
- perf_flush_cnt  out  32  flush-event counter (optional feature)

Behaviour:
- State: pc_q[31:0], valid_q, instr_hold[31:0], hold_sel.
- Outputs:
  - PC_id = pc_q.
  - valid_id = valid_q.
  - instr_id = NOP_INSTR if !valid_q; instr_hold if hold_sel; imem_rdata otherwise.
  - fetch_hold = stall_id & ~flush_id (combinational).
  - imem_addr = PC_if (combinational).
- Reset (rst=1 at posedge): pc_q=RESET_PC, valid_q=0, hold_sel=0, instr_hold=0.
  - Outputs after reset: valid_id=0, instr_id=NOP_INSTR, misaligned_id=0.
- Latency: PC_if presented in cycle n appears as PC_id with the matching instr_id in cycle n+1. First valid instruction appears one cycle after rst deasserts.
- Priority at each posedge: rst > flush_id > stall_id > advance.
  - Flush: valid_q<=0, hold_sel<=0, pc_q<=PC_if. Flush overrides a simultaneous stall; fetch_hold is 0 so fetch takes the branch target.
  - Stall, hold_sel=0: pc_q and valid_q unchanged; instr_hold<=imem_rdata; hold_sel<=1. This captures the correct word before the RAM returns data for the held fetch address.
  - Stall, hold_sel=1: all state unchanged; instr_id stays instr_hold for the whole stall.
  - Advance (no stall, no flush): pc_q<=PC_if, valid_q<=1, hold_sel<=0.
- Why the hold register is needed: during a stall the RAM output becomes instr(PC_if), not instr(pc_q). After release the RAM output again corresponds to the new pc_q with no bubble.
- Stall on an invalid slot: state is held as above. instr_id stays NOP_INSTR because valid_q=0.
- Back-to-back flushes: each produces an invalid slot.
- Flush on the cycle a stall is released: flush semantics apply.
- Reset mid-stall: clears hold_sel. The next posedge with rst=0 captures PC_if normally.
- No arithmetic is done on the PC here; PC + 4 stays in fetch.
- misaligned_id = valid_q & (pc_q[1:0] != 2'b00). It is combinational from registered state.

Optional Feature:
- Macro IF_ID_PERF_EN.
- Defined:
  - perf_stall_cnt increments on every posedge where stall_id=1 and flush_id=0 and rst=0.
  - perf_flush_cnt increments on every posedge where flush_id=1 and rst=0.
  - Both are 32-bit, wrap from 0xFFFFFFFF to 0, and reset to 0.
- Undefined: both ports remain and are tied to 32'h0. No counter flops are inferred.

Test Plan:
- Reset release, PC_if stepping 0,4,8 with imem returning 0xA0000000|addr one cycle later:
  - cycle after release: PC_id=0, instr_id=0xA0000000, valid_id=1.
  - following cycles: PC_id=4, then 8, with matching words.
- Stall 3 cycles with pc_q=8 while the RAM changes to 0xA000000C: PC_id=8 and instr_id=0xA0000008 held all 3 cycles, fetch_hold=1. After release, PC_id=0xC, instr_id=0xA000000C.
- flush_id=1 with PC_if=0x10 and stall_id=1 simultaneously: fetch_hold=0. Next cycle valid_id=0, instr_id=0x00000013, PC_id=0x10.
- rst asserted during a 2-cycle stall: next cycle valid_id=0, instr_id=NOP_INSTR, PC_id=0. After release, normal capture resumes.
- PC_if=0x22 captured: next cycle misaligned_id=1, valid_id=1. The same PC captured during a flush gives misaligned_id=0.
- With IF_ID_PERF_EN: 5 stall cycles and 2 flushes give perf_stall_cnt=5, perf_flush_cnt=2. Counter preloaded to 0xFFFFFFFF wraps to 0 on the next stall. Without the macro, both counters read 0.
